// File: rtl/paint_cursor.sv
// Joystick-driven paint cursor: moves a cursor over a 160x120 canvas and issues
// framebuffer writes for painting, erasing and clearing the whole canvas.
module paint_cursor #(
    parameter int STEP_DIV = 2000000,
    parameter int DEAD     = 64,
    parameter int FAST     = 320
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        jstk_valid,
    input  logic [9:0]  jstk_x,
    input  logic [9:0]  jstk_y,
    input  logic [2:0]  btn,
    input  logic [2:0]  sw,
    input  logic        wr_ready,
    output logic [7:0]  cur_x,
    output logic [6:0]  cur_y,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        busy
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
    localparam logic [14:0]   LAST_ADDR = 15'd19199;

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [9:0]    sample_x, sample_y;
    logic          btn2_prev, btn2_edge;
    logic          tick_pend, tick_pend_n;
    logic          clr_pend, clr_pend_n;
    logic [7:0]    cur_x_n, move_x;
    logic [6:0]    cur_y_n, move_y;
    logic [14:0]   paint_addr;
    logic          wr_en_n, busy_n;
    logic [14:0]   wr_addr_n;
    logic [2:0]    wr_data_n;
    int            mx, my;

    // Signed step for one axis: positive when the stick is above centre.
    function automatic int step_of(input logic [9:0] s);
        int v;
        int r;
        v = int'(s);
        if (v > 512 + FAST)      r = 2;
        else if (v > 512 + DEAD) r = 1;
        else if (v < 512 - FAST) r = -2;
        else if (v < 512 - DEAD) r = -1;
        else                     r = 0;
        return r;
    endfunction

    function automatic int clamp(input int v, input int hi);
        int r;
        if (v < 0)       r = 0;
        else if (v > hi) r = hi;
        else             r = v;
        return r;
    endfunction

    assign tick      = (cnt == CNT_LAST);
    assign btn2_edge = btn[2] & ~btn2_prev;

    // Candidate position after one tick; Y grows downward, so stick-up decrements it.
    always_comb begin
        mx         = clamp(int'(cur_x) + step_of(sample_x), 159);
        my         = clamp(int'(cur_y) - step_of(sample_y), 119);
        move_x     = 8'(mx);
        move_y     = 7'(my);
        paint_addr = 15'(my * 160 + mx);
    end

    always_comb begin
        state_n     = state;
        cur_x_n     = cur_x;
        cur_y_n     = cur_y;
        wr_en_n     = wr_en;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        busy_n      = busy;
        tick_pend_n = tick_pend;
        clr_pend_n  = clr_pend;
        case (state)
            IDLE: begin
                wr_en_n = 1'b0;
                busy_n  = 1'b0;
                // A pending or fresh clear wins over a tick; the tick waits for the next IDLE.
                if (clr_pend || btn2_edge) begin
                    state_n     = CLEAR;
                    clr_pend_n  = 1'b0;
                    tick_pend_n = tick | tick_pend;
                    busy_n      = 1'b1;
                    wr_en_n     = 1'b1;
                    wr_addr_n   = '0;
                    wr_data_n   = 3'b000;
                end else if (tick || tick_pend) begin
                    tick_pend_n = 1'b0;
                    cur_x_n     = move_x;
                    cur_y_n     = move_y;
                    if (btn[1] || btn[0]) begin
                        state_n   = PAINT;
                        wr_en_n   = 1'b1;
                        wr_addr_n = paint_addr;
                        wr_data_n = btn[1] ? 3'b000 : sw;
                    end
                end
            end
            PAINT: begin
                tick_pend_n = tick_pend | tick;
                clr_pend_n  = clr_pend | btn2_edge;
                if (wr_ready) begin
                    wr_en_n = 1'b0;
                    state_n = IDLE;
                end
            end
            CLEAR: begin
                tick_pend_n = tick_pend | tick;
                if (wr_ready) begin
                    if (wr_addr == LAST_ADDR) begin
                        state_n = IDLE;
                        wr_en_n = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        wr_addr_n = wr_addr + 15'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                wr_en_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // btn2_prev resets high so a button held through reset cannot start a clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            cur_x     <= 8'd80;
            cur_y     <= 7'd60;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 3'b000;
            busy      <= 1'b0;
            sample_x  <= 10'd512;
            sample_y  <= 10'd512;
            cnt       <= '0;
            tick_pend <= 1'b0;
            clr_pend  <= 1'b0;
            btn2_prev <= 1'b1;
        end else begin
            state     <= state_n;
            cur_x     <= cur_x_n;
            cur_y     <= cur_y_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            busy      <= busy_n;
            tick_pend <= tick_pend_n;
            clr_pend  <= clr_pend_n;
            btn2_prev <= btn[2];
            if (jstk_valid) begin
                sample_x <= jstk_x;
                sample_y <= jstk_y;
            end
            if (tick) cnt <= '0;
            else      cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_paint_cursor.sv
// Directed self-checking bench for paint_cursor with a fast step tick (STEP_DIV=8).
module tb_paint_cursor;

    logic        clk = 1'b0;
    logic        clr;
    logic        jstk_valid;
    logic [9:0]  jstk_x, jstk_y;
    logic [2:0]  btn, sw;
    logic        wr_ready;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;

    paint_cursor #(.STEP_DIV(8), .DEAD(64), .FAST(320)) dut (
        .clk(clk), .clr(clr), .jstk_valid(jstk_valid), .jstk_x(jstk_x), .jstk_y(jstk_y),
        .btn(btn), .sw(sw), .wr_ready(wr_ready), .cur_x(cur_x), .cur_y(cur_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en && wr_ready) xfers++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] b, input logic [2:0] s, input logic r);
        btn = b;
        sw = s;
        wr_ready = r;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle joystick strobe; the sample lands on the next edge.
    task automatic strobeJoystick(input int x, input int y);
        jstk_x = 10'(x);
        jstk_y = 10'(y);
        jstk_valid = 1'b1;
        cycles(1);
        jstk_valid = 1'b0;
    endtask

    task automatic waitWrite(input string tag);
        int n = 0;
        while (!wr_en && n < 24) begin
            cycles(1);
            n++;
        end
        checkOutput(tag, 32'(wr_en), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        clr = 1'b1;
        jstk_valid = 1'b0;
        jstk_x = 10'd512;
        jstk_y = 10'd512;
        applyStimulus(3'b100, 3'b000, 1'b0);
        cycles(3);
        clr = 1'b0;
        checkOutput("rst_cur_x", 32'(cur_x), 32'd80);
        checkOutput("rst_cur_y", 32'(cur_y), 32'd60);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        cycles(20);
        checkOutput("held_btn2_busy", 32'(busy), 32'd0);
        checkOutput("held_btn2_wr_en", 32'(wr_en), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        $display("[TB] cursor motion");
        strobeJoystick(1000, 512);
        cycles(5 * 8);
        checkOutput("x_fast_5ticks", 32'(cur_x), 32'd90);
        cycles(40 * 8);
        checkOutput("x_sat_159", 32'(cur_x), 32'd159);
        checkOutput("y_idle", 32'(cur_y), 32'd60);
        strobeJoystick(512, 560);
        cycles(10 * 8);
        checkOutput("y_deadzone", 32'(cur_y), 32'd60);
        checkOutput("x_centre_hold", 32'(cur_x), 32'd159);
        strobeJoystick(512, 0);
        cycles(3 * 8);
        checkOutput("y_down_fast", 32'(cur_y), 32'd66);
        strobeJoystick(400, 1023);
        cycles(40 * 8);
        checkOutput("x_slow_left", 32'(cur_x), 32'd119);
        checkOutput("y_sat_0", 32'(cur_y), 32'd0);

        $display("[TB] paint with stalled ready");
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        checkOutput("rst2_cur_x", 32'(cur_x), 32'd80);
        checkOutput("rst2_cur_y", 32'(cur_y), 32'd60);
        applyStimulus(3'b001, 3'b101, 1'b0);
        base = xfers;
        waitWrite("paint_wr_en");
        btn = 3'b000;
        for (int c = 0; c < 4; c++) begin
            checkOutput("paint_hold_en", 32'(wr_en), 32'd1);
            checkOutput("paint_addr", 32'(wr_addr), 32'd9680);
            checkOutput("paint_data", 32'(wr_data), 32'd5);
            if (c == 3) wr_ready = 1'b1;
            cycles(1);
        end
        checkOutput("paint_done_en", 32'(wr_en), 32'd0);
        cycles(16);
        checkOutput("paint_one_xfer", 32'(xfers - base), 32'd1);
        checkOutput("paint_idle_en", 32'(wr_en), 32'd0);

        $display("[TB] erase priority");
        applyStimulus(3'b011, 3'b111, 1'b1);
        waitWrite("erase_wr_en");
        btn = 3'b000;
        checkOutput("erase_data", 32'(wr_data), 32'd0);
        checkOutput("erase_addr", 32'(wr_addr), 32'd9680);
        cycles(1);
        checkOutput("erase_done_en", 32'(wr_en), 32'd0);

        $display("[TB] full canvas clear");
        btn = 3'b100;
        cycles(1);
        btn = 3'b000;
        for (int i = 0; i < 19200; i++) begin
            checkOutput("clear_seq", {12'd0, busy, wr_en, wr_data, wr_addr},
                        {12'd0, 1'b1, 1'b1, 3'b000, 15'(i)});
            jstk_valid = (i == 10);
            if (i == 10) jstk_x = 10'd1000;
            cycles(1);
        end
        checkOutput("clear_end_busy", 32'(busy), 32'd0);
        checkOutput("clear_end_en", 32'(wr_en), 32'd0);
        checkOutput("clear_no_move_x", 32'(cur_x), 32'd80);
        checkOutput("clear_no_move_y", 32'(cur_y), 32'd60);
        cycles(1);
        checkOutput("pending_tick_x", 32'(cur_x), 32'd82);

        $display("[TB] reset during clear");
        btn = 3'b100;
        cycles(1);
        btn = 3'b000;
        checkOutput("clear2_busy", 32'(busy), 32'd1);
        n = 0;
        while (!(busy && wr_addr == 15'd500) && n < 1000) begin
            cycles(1);
            n++;
        end
        checkOutput("clear2_reach_500", 32'(wr_addr), 32'd500);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_cur_x", 32'(cur_x), 32'd80);
        checkOutput("abort_cur_y", 32'(cur_y), 32'd60);
        checkOutput("abort_wr_addr", 32'(wr_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/paint_cursor.md
PAINT_CURSOR -- requirements
Module: paint_cursor

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 2000000, meaning clk cycles per cursor-step tick (minimum 4).
REQ-002 The block SHALL have parameter DEAD, default 64, meaning joystick deadzone half-width around centre 512.
REQ-003 The block SHALL have parameter FAST, default 320, meaning offset from centre beyond which the step size is 2.
REQ-004 The block SHALL have port clk, input, 1, the 100 MHz system clock; the only clock.
REQ-005 The block SHALL have port clr, input, 1, the reset: synchronous and active-high.
REQ-006 The block SHALL have port jstk_valid, input, 1, a one-cycle strobe that marks a new joystick sample.
REQ-007 The block SHALL have port jstk_x, input, 10, the joystick X position (0..1023).
REQ-008 The block SHALL have port jstk_y, input, 10, the joystick Y position (0..1023).
REQ-009 The block SHALL have port btn, input, 3, the joystick buttons: [0] paint, [1] erase, [2] clear canvas.
REQ-010 The block SHALL have port sw, input, 3, the paint colour {R,G,B}.
REQ-011 The block SHALL have port wr_ready, input, 1, the framebuffer write-accept signal.
REQ-012 The block SHALL have port cur_x, output, 8, the cursor column (0..159).
REQ-013 The block SHALL have port cur_y, output, 7, the cursor row (0..119).
REQ-014 The block SHALL have port wr_en, output, 1, the framebuffer write request.
REQ-015 The block SHALL have port wr_addr, output, 15, the framebuffer address.
REQ-016 The block SHALL have port wr_data, output, 3, the framebuffer pixel colour.
REQ-017 The block SHALL have port busy, output, 1, which is high while a canvas clear is in progress.

Function
REQ-018 The block SHALL register jstk_x/jstk_y into sample registers on cycles where jstk_valid=1 and hold them otherwise.
REQ-019 The block SHALL generate a one-cycle tick every STEP_DIV cycles from a free-running counter that counts 0..STEP_DIV-1 and wraps.
REQ-020 The block SHALL, on a tick in IDLE, move X: sample>512+FAST gives +2; sample>512+DEAD gives +1; sample<512-FAST gives -2; sample<512-DEAD gives -1; otherwise no change.
REQ-021 The block SHALL move Y with the same rule, except a sample above centre decrements cur_y (up) and a sample below centre increments cur_y.
REQ-022 The block SHALL saturate cursor arithmetic at 0 and 159 (X) and at 0 and 119 (Y); no wrap-around.
REQ-023 The block SHALL use FSM states IDLE, PAINT and CLEAR.
REQ-024 The block SHALL, on a tick in IDLE with btn[1] or btn[0] high, apply the move and go to PAINT the next cycle, with the write targeting the updated position.
REQ-025 The block SHALL, in PAINT, set wr_addr=cur_y*160+cur_x and set wr_data=3'b000 if btn[1] was high at the tick, else sw as sampled at the tick; erase has priority.
REQ-026 The block SHALL detect the btn[2] rising edge (registered previous value); when detected in IDLE, it SHALL go to CLEAR with busy=1 on the next cycle.
REQ-027 The block SHALL, in CLEAR, write wr_data=0 to addresses 0..19199 in ascending order, one per accepted write; after address 19199 is accepted it SHALL return to IDLE with busy=0.
REQ-028 Handshake: wr_en SHALL assert in PAINT/CLEAR, and addr/data SHALL be held stable while wr_en=1 and wr_ready=0.
REQ-029 Handshake: a write SHALL transfer on the cycle where wr_en=1 and wr_ready=1.
REQ-030 Handshake: PAINT SHALL return to IDLE after its transfer.
REQ-031 Handshake: wr_en SHALL be 0 in IDLE.
REQ-032 The block SHALL latch a tick that occurs outside IDLE into a 1-bit pending flag (further ticks merge into it) and service it on the first IDLE cycle; no movement occurs during CLEAR/PAINT.
REQ-033 The block SHALL latch a btn[2] edge seen during PAINT as a pending clear, taken on return to IDLE; an edge during CLEAR SHALL be ignored.
REQ-034 The block SHALL, when a pending clear and a tick coincide in IDLE, service the clear first, keeping the tick pending.
REQ-035 The block SHALL drive cur_x/cur_y from registers that update on the cycle after the tick.

Reset
REQ-036 The block SHALL, on clr=1 at a clk edge, set: state IDLE, cur_x=80, cur_y=60, wr_en=0, wr_addr=0, wr_data=0, busy=0, sample registers=512, tick counter=0, pending flags=0, previous btn[2]=1 (no false clear after reset).
REQ-037 The block SHALL let clr abort any write or clear mid-operation, with the above values on the next cycle.

Verification
REQ-038 Verification: STEP_DIV=8, jstk_x=1000 strobed, 5 ticks -> cur_x 80->90; a further 40 ticks -> cur_x=159 held.
REQ-039 Verification: jstk_y=560 (inside deadzone), 10 ticks -> cur_y=60 unchanged; jstk_y=0 -> cur_y increments by 2 per tick.
REQ-040 Verification: btn[0]=1, sw=3'b101, cursor (80,60), jstk centred, wr_ready low 3 cycles then high -> wr_addr=9680 and wr_data=5 stable for 4 cycles, one transfer, then IDLE.
REQ-041 Verification: btn[2] pulse with wr_ready=1 -> busy high for 19200 writes at addresses 0..19199 with data 0, ticks during the clear cause no movement, and one pending tick is serviced after the clear.
REQ-042 Verification: btn[0]=1 and btn[1]=1 together -> wr_data=0; clr asserted mid-CLEAR at address 500 -> busy=0, wr_en=0, cursor (80,60) on the next cycle.
REQ-043 Verification: btn[2] held high across reset release -> no clear started.
